// File: rtl/median_axis_pixel_transmitter_if.sv
// rtl/median_axis_pixel_transmitter_if.sv - AXI4-Stream pixel bus between the transmitter and its sink
interface median_axis_pixel_transmitter_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tuser;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/median_axis_pixel_transmitter.sv
// rtl/median_axis_pixel_transmitter.sv - median pixels to AXIS with regenerated framing, FIFO and back-pressure
// Optional border blanking: define MEDIAN_TX_BORDER_BLANK_EN.
module median_axis_pixel_transmitter #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 4096,
    parameter int IMG_HEIGHT  = 3072,
    parameter int KERNEL_SIZE = 5,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                            i_clk,
    input  logic                            i_aresetn,
    input  logic [DATA_WIDTH-1:0]           i_median_pixel,
    input  logic                            i_image_data_valid,
    input  logic                            i_start_of_frame,
    median_axis_pixel_transmitter_if.master m_axis,
    output logic                            o_overflow,
    output logic                            o_frame_done,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [LW-1:0]   wptr_q, wptr_d;
    logic [LW-1:0]   rptr_q, rptr_d;
    logic            out_valid_q, out_valid_d;
    logic [WW-1:0]   out_word_q, out_word_d;
    logic            overflow_q, overflow_d;
    logic            frame_done_q, frame_done_d;
    logic [WW-1:0]   mem_q [FIFO_DEPTH];

    logic                  take;
    logic [CW-1:0]         cur_col;
    logic [RW-1:0]         cur_row;
    logic                  line_end;
    logic                  frame_end;
    logic [DATA_WIDTH-1:0] pix_data;
    logic [WW-1:0]         wr_word;
    logic [LW-1:0]         mem_count;
    logic [LW-1:0]         level;
    logic                  mem_empty;
    logic                  fifo_full;
    logic                  rd_fire;
    logic                  wr_en;
    logic                  load;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q      <= WAIT_SOF;
            col_q        <= '0;
            row_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage array carries no reset; the pointers alone define its contents.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= wr_word;
        end
    end

    always_comb begin
        state_d = state_q;
        if (take) begin
            state_d = frame_end ? WAIT_SOF : ACTIVE;
        end
    end

    always_comb begin
        // A sof pixel always restarts the frame, even mid-line.
        take      = i_image_data_valid && (i_start_of_frame || (state_q == ACTIVE));
        cur_col   = i_start_of_frame ? '0 : col_q;
        cur_row   = i_start_of_frame ? '0 : row_q;
        line_end  = (cur_col == COL_LAST);
        frame_end = take && line_end && (cur_row == ROW_LAST);

        col_d = col_q;
        row_d = row_q;
        if (take) begin
            if (frame_end) begin
                col_d = '0;
                row_d = '0;
            end else if (line_end) begin
                col_d = '0;
                row_d = cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end

`ifdef MEDIAN_TX_BORDER_BLANK_EN
        if ((int'(cur_row) < KERNEL_SIZE / 2) || (int'(cur_col) < KERNEL_SIZE / 2) ||
            (int'(cur_row) > IMG_HEIGHT - 1 - KERNEL_SIZE / 2) ||
            (int'(cur_col) > IMG_WIDTH - 1 - KERNEL_SIZE / 2)) begin
            pix_data = '0;
        end else begin
            pix_data = i_median_pixel;
        end
`else
        pix_data = i_median_pixel;
`endif
        wr_word = {(cur_row == '0) && (cur_col == '0), line_end, pix_data};

        // Capacity includes the output register, so full means level == FIFO_DEPTH.
        mem_count = wptr_q - rptr_q;
        mem_empty = (wptr_q == rptr_q);
        level     = mem_count + LW'(out_valid_q);
        fifo_full = (level == LW'(FIFO_DEPTH));
        rd_fire   = out_valid_q && m_axis.tready;
        wr_en     = take && (!fifo_full || rd_fire);
        load      = !mem_empty && (!out_valid_q || rd_fire);

        wptr_d       = wptr_q + LW'(wr_en);
        rptr_d       = rptr_q + LW'(load);
        out_valid_d  = load ? 1'b1 : (rd_fire ? 1'b0 : out_valid_q);
        out_word_d   = load ? mem_q[rptr_q[AW-1:0]] : out_word_q;
        overflow_d   = overflow_q || (take && !wr_en);
        frame_done_d = frame_end;
    end

    always_comb begin
        m_axis.tvalid = out_valid_q;
        m_axis.tuser  = out_word_q[WW-1];
        m_axis.tlast  = out_word_q[WW-2];
        m_axis.tdata  = out_word_q[DATA_WIDTH-1:0];
        o_overflow    = overflow_q;
        o_frame_done  = frame_done_q;
        o_fifo_level  = level;
    end
endmodule
